// File: rtl/sys_arr_out_collector.sv
// sys_arr_out_collector
// Read side of the systolic array. Each column's maccout/activeout lane is
// delayed so that all lanes of one result row line up on the same cycle.
// Complete rows are queued in a small FIFO and handed to the output buffer
// over valid/ready. The array cannot be back-pressured, so the block raises
// an early stall warning. Rows lost to overflow or to misaligned active bits
// are flagged in sticky error bits.
module sys_arr_out_collector #(
  parameter int COLS  = 2,
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [COLS*WIDTH-1:0] maccin,
  input  logic [COLS-1:0]       activein,
  output logic [COLS*WIDTH-1:0] rowout,
  output logic                  rowvalid,
  input  logic                  rowready,
  output logic                  stall,
  output logic [15:0]           rowcnt,
  output logic                  ovf_err,
  output logic                  skew_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] COLS_C  = CW'(COLS);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [AW-1:0] PTR_INC = AW'(1);

  // ---------------------------------------------------------------------
  // Deskew: lane c lags lane 0 by c cycles, so it is held back by
  // COLS-1-c register stages. The last lane is used as it arrives.
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] lane_data [COLS];
  logic             lane_act  [COLS];

  for (genvar c = 0; c < COLS; c++) begin : g_lane
    localparam int STAGES = COLS - 1 - c;

    if (STAGES == 0) begin : g_pass
      assign lane_data[c] = maccin[c*WIDTH +: WIDTH];
      assign lane_act[c]  = activein[c];
    end else begin : g_dly
      logic [WIDTH-1:0] data_sr [STAGES];
      logic             act_sr  [STAGES];

      // Shift chain for this lane; reset drops any partially deskewed row.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < STAGES; i++) begin
            data_sr[i] <= '0;
            act_sr[i]  <= 1'b0;
          end
        end else begin
          data_sr[0] <= maccin[c*WIDTH +: WIDTH];
          act_sr[0]  <= activein[c];
          for (int i = 1; i < STAGES; i++) begin
            data_sr[i] <= data_sr[i-1];
            act_sr[i]  <= act_sr[i-1];
          end
        end
      end

      assign lane_data[c] = data_sr[STAGES-1];
      assign lane_act[c]  = act_sr[STAGES-1];
    end
  end

  // ---------------------------------------------------------------------
  // Row detect on the aligned lanes.
  // ---------------------------------------------------------------------
  logic [COLS*WIDTH-1:0] row_data;
  logic [COLS-1:0]       row_act;
  logic                  push_req;
  logic                  skew_hit;

  // Re-pack the aligned lanes into a row with the same layout as maccin.
  always_comb begin
    row_data = '0;
    row_act  = '0;
    for (int c = 0; c < COLS; c++) begin
      row_data[c*WIDTH +: WIDTH] = lane_data[c];
      row_act[c]                 = lane_act[c];
    end
  end

  // A full row needs every lane active; a partial set means the columns
  // slipped relative to each other and the row cannot be trusted.
  assign push_req = &row_act;
  assign skew_hit = (|row_act) & ~(&row_act);

  // ---------------------------------------------------------------------
  // Row FIFO
  // ---------------------------------------------------------------------
  logic [COLS*WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_next;
  logic                  pop;
  logic                  push;
  logic                  drop;
  logic                  stall_next;

  // Push/pop decision. A full FIFO can still take a row when the consumer
  // frees the head in the same cycle.
  always_comb begin
    pop        = 1'b0;
    push       = 1'b0;
    drop       = 1'b0;
    count_next = count;
    stall_next = 1'b0;

    pop  = (count != '0) & rowready;
    push = push_req & ((count < DEPTH_C) | pop);
    drop = push_req & ~push;

    case ({push, pop})
      2'b10:   count_next = count + ONE_C;
      2'b01:   count_next = count - ONE_C;
      default: count_next = count;
    endcase

    stall_next = (DEPTH_C - count_next) <= COLS_C;
  end

  // FIFO bookkeeping, row counter, early stall flag and sticky errors.
  // stall is computed from the next count so it lines up with count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      stall    <= 1'b0;
      rowcnt   <= '0;
      ovf_err  <= 1'b0;
      skew_err <= 1'b0;
    end else begin
      count <= count_next;
      stall <= stall_next;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_INC;
        rowcnt <= rowcnt + 16'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_INC;
      end
      if (drop) begin
        ovf_err <= 1'b1;
      end
      if (skew_hit) begin
        skew_err <= 1'b1;
      end
    end
  end

  // Row storage; contents are only visible while the entry is occupied,
  // so it needs no reset.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= row_data;
    end
  end

  // Head of FIFO only; nothing from maccin/activein reaches these outputs
  // without passing through the FIFO first.
  assign rowvalid = (count != '0);
  assign rowout   = rowvalid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_sys_arr_out_collector.sv
// Bench for sys_arr_out_collector (COLS=2, WIDTH=16, DEPTH=4).
// Reference model: a queue of rows; a row counts as aligned when its lane 0
// was driven active one cycle before its lane 1.
module tb_sys_arr_out_collector;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] maccin = '0;
  logic [1:0]  activein = '0;
  logic [31:0] rowout;
  logic        rowvalid;
  logic        rowready = 1'b0;
  logic        stall;
  logic [15:0] rowcnt;
  logic        ovf_err;
  logic        skew_err;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [31:0] q[$];
  logic [15:0] m_cnt  = '0;
  logic        m_ovf  = 1'b0;
  logic        m_skew = 1'b0;
  logic [15:0] prev_d0 = '0;
  logic        prev_a0 = 1'b0;
  logic [15:0] pend_d1 = '0;
  logic        pend_a1 = 1'b0;

  sys_arr_out_collector #(.COLS(2), .WIDTH(16), .DEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .maccin   (maccin),
    .activein (activein),
    .rowout   (rowout),
    .rowvalid (rowvalid),
    .rowready (rowready),
    .stall    (stall),
    .rowcnt   (rowcnt),
    .ovf_err  (ovf_err),
    .skew_err (skew_err)
  );

  always #5 clk = ~clk;

  task automatic check_all(input string tag);
    logic [31:0] exp_out;
    logic        exp_valid;
    logic        exp_stall;
    exp_valid = (q.size() != 0);
    exp_out   = exp_valid ? q[0] : 32'h0;
    exp_stall = ((4 - q.size()) <= 2);
    total++;
    assert (rowvalid === exp_valid) else begin
      bad++; $error("FAIL %s rowvalid got=%0b exp=%0b", tag, rowvalid, exp_valid);
    end
    total++;
    assert (rowout === exp_out) else begin
      bad++; $error("FAIL %s rowout got=%h exp=%h", tag, rowout, exp_out);
    end
    total++;
    assert (stall === exp_stall) else begin
      bad++; $error("FAIL %s stall got=%0b exp=%0b", tag, stall, exp_stall);
    end
    total++;
    assert (rowcnt === m_cnt) else begin
      bad++; $error("FAIL %s rowcnt got=%0d exp=%0d", tag, rowcnt, m_cnt);
    end
    total++;
    assert (ovf_err === m_ovf) else begin
      bad++; $error("FAIL %s ovf_err got=%0b exp=%0b", tag, ovf_err, m_ovf);
    end
    total++;
    assert (skew_err === m_skew) else begin
      bad++; $error("FAIL %s skew_err got=%0b exp=%0b", tag, skew_err, m_skew);
    end
  endtask

  // One clock cycle: optionally start a row (lane 0 now, lane 1 next cycle),
  // present lane 1 of the row started last cycle, update the model, check.
  task automatic cyc(input logic iss, input logic [15:0] d0, input logic [15:0] d1,
                     input logic a1_ok, input logic rdy, input string tag);
    logic [15:0] cur_d0;
    logic [15:0] cur_d1;
    logic        cur_a1;
    logic        pop;
    logic        acc;
    cur_d0 = iss ? d0 : 16'($urandom);
    cur_d1 = pend_a1 ? pend_d1 : 16'($urandom);
    cur_a1 = pend_a1;
    maccin   = {cur_d1, cur_d0};
    activein = {cur_a1, iss};
    rowready = rdy;
    pop = (q.size() != 0) && rdy;
    acc = 1'b0;
    if (prev_a0 && cur_a1) begin
      if (q.size() < 4 || pop) acc = 1'b1;
      else m_ovf = 1'b1;
    end else if (prev_a0 != cur_a1) begin
      m_skew = 1'b1;
    end
    @(posedge clk); #1;
    if (pop) void'(q.pop_front());
    if (acc) begin
      q.push_back({cur_d1, prev_d0});
      m_cnt = m_cnt + 16'd1;
    end
    prev_d0 = cur_d0;
    prev_a0 = iss;
    pend_d1 = d1;
    pend_a1 = iss & a1_ok;
    check_all(tag);
  endtask

  // One reset cycle; a pending lane 1 is still driven while reset is high.
  task automatic do_reset(input string tag);
    reset    = 1'b1;
    maccin   = {pend_d1, 16'($urandom)};
    activein = {pend_a1, 1'b0};
    rowready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    activein = '0;
    q.delete();
    m_cnt = '0; m_ovf = 1'b0; m_skew = 1'b0;
    prev_a0 = 1'b0; prev_d0 = '0;
    pend_a1 = 1'b0;
    check_all(tag);
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while ((q.size() != 0 || pend_a1) && guard < 64) begin
      cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b1, tag);
      guard++;
    end
    total++;
    assert (guard < 64) else begin
      bad++; $error("FAIL %s_timeout got=%0d exp=<64", tag, guard);
    end
  endtask

  initial begin
    int issued;
    int guard;
    logic iss;

    // reset state
    do_reset("reset0");

    // 1: single row
    cyc(1'b1, 16'h0011, 16'h0022, 1'b1, 1'b0, "t1_c0");
    cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, "t1_c1");
    total++;
    assert (rowout === 32'h0022_0011 && rowvalid === 1'b1) else begin
      bad++; $error("FAIL t1_row got=%h/%0b exp=00220011/1", rowout, rowvalid);
    end
    total++;
    assert (rowcnt === 16'd1) else begin
      bad++; $error("FAIL t1_cnt got=%0d exp=1", rowcnt);
    end
    drain("t1_drain");

    // 2: four rows with no consumer, then an overflowing fifth
    do_reset("t2_reset");
    for (int k = 1; k <= 4; k++)
      cyc(1'b1, 16'h0100 + 16'(k), 16'h0200 + 16'(k), 1'b1, 1'b0, "t2_fill");
    cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, "t2_full");
    cyc(1'b1, 16'h0105, 16'h0205, 1'b1, 1'b0, "t2_fifth");
    cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, "t2_ovf");
    total++;
    assert (ovf_err === 1'b1 && rowcnt === 16'd4 && stall === 1'b1) else begin
      bad++; $error("FAIL t2_ovf got=%0b/%0d/%0b exp=1/4/1", ovf_err, rowcnt, stall);
    end
    total++;
    assert (rowout === 32'h0201_0101) else begin
      bad++; $error("FAIL t2_head got=%h exp=02010101", rowout);
    end
    drain("t2_drain");

    // 3: full FIFO, consumer pops while the fifth row aligns
    do_reset("t3_reset");
    for (int k = 1; k <= 4; k++)
      cyc(1'b1, 16'h0300 + 16'(k), 16'h0400 + 16'(k), 1'b1, 1'b0, "t3_fill");
    cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, "t3_full");
    cyc(1'b1, 16'h0305, 16'h0405, 1'b1, 1'b0, "t3_fifth");
    cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b1, "t3_swap");
    total++;
    assert (ovf_err === 1'b0 && rowcnt === 16'd5 && stall === 1'b1) else begin
      bad++; $error("FAIL t3_swap got=%0b/%0d/%0b exp=0/5/1", ovf_err, rowcnt, stall);
    end
    total++;
    assert (rowout === 32'h0402_0302) else begin
      bad++; $error("FAIL t3_head got=%h exp=04020302", rowout);
    end
    drain("t3_drain");

    // 4: lane 1 missing its active bit
    do_reset("t4_reset");
    cyc(1'b1, 16'h0aaa, 16'h0bbb, 1'b0, 1'b0, "t4_c0");
    cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, "t4_c1");
    total++;
    assert (skew_err === 1'b1 && rowvalid === 1'b0 && rowcnt === 16'd0) else begin
      bad++; $error("FAIL t4_skew got=%0b/%0b/%0d exp=1/0/0", skew_err, rowvalid, rowcnt);
    end
    repeat (3) cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b1, "t4_hold");
    cyc(1'b1, 16'h0ccc, 16'h0ddd, 1'b1, 1'b0, "t4_ok0");
    cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, "t4_ok1");
    drain("t4_drain");

    // 5: reset with two rows queued and one mid-deskew
    do_reset("t5_reset");
    cyc(1'b1, 16'h0501, 16'h0601, 1'b1, 1'b0, "t5_q1");
    cyc(1'b1, 16'h0502, 16'h0602, 1'b1, 1'b0, "t5_q2");
    cyc(1'b1, 16'h0503, 16'h0603, 1'b1, 1'b0, "t5_mid");
    do_reset("t5_pulse");
    total++;
    assert ({rowvalid, rowout, stall, rowcnt, ovf_err, skew_err} === 52'h0) else begin
      bad++; $error("FAIL t5_zero got=%0b/%h/%0b/%0d/%0b/%0b exp=all0",
                    rowvalid, rowout, stall, rowcnt, ovf_err, skew_err);
    end
    cyc(1'b1, 16'h0777, 16'h0888, 1'b1, 1'b0, "t5_after0");
    cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, "t5_after1");
    total++;
    assert (rowvalid === 1'b1 && rowout === 32'h0888_0777) else begin
      bad++; $error("FAIL t5_row got=%0b/%h exp=1/08880777", rowvalid, rowout);
    end
    drain("t5_drain");

    // 6: random traffic, 50% rowready, issuing only while stall is low
    do_reset("t6_reset");
    issued = 0;
    guard  = 0;
    while (issued < 1000 && guard < 20000) begin
      iss = (stall === 1'b0) && ($urandom_range(0, 3) != 0);
      cyc(iss, 16'($urandom), 16'($urandom), 1'b1, 1'($urandom_range(0, 1)), "t6_rand");
      if (iss) issued++;
      guard++;
    end
    total++;
    assert (issued == 1000) else begin
      bad++; $error("FAIL t6_timeout got=%0d exp=1000", issued);
    end
    drain("t6_drain");
    total++;
    assert (rowcnt === 16'd1000 && ovf_err === 1'b0 && skew_err === 1'b0) else begin
      bad++; $error("FAIL t6_final got=%0d/%0b/%0b exp=1000/0/0", rowcnt, ovf_err, skew_err);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
